// File: rtl/square_wave_mc.sv
`default_nettype none
// ============================================================================
//  Module      : square_wave_mc
//  Description : Multi-channel phase-accumulator square-wave generator with
//                shadowed per-channel config applied at phase wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module square_wave_mc #(
    parameter int NCH   = 4,
    parameter int ACC_W = 16,
    parameter int OUT_W = 16,
    parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sync,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic                 cfg_en,
    input  logic [ACC_W-1:0]     cfg_step,
    input  logic [ACC_W-1:0]     cfg_duty,
    input  logic [ACC_W-1:0]     cfg_phase,
    output logic                 cfg_err,
    output logic [NCH*OUT_W-1:0] wave_out,
    output logic [NCH-1:0]       wrap
);

    localparam logic [CH_W:0]      c_nch      = (CH_W + 1)'(NCH);
    localparam logic [OUT_W-1:0]   c_high     = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0]   c_low      = {1'b1, {(OUT_W - 1){1'b0}}};
    localparam logic [ACC_W-1:0]   c_duty_rst = {1'b1, {(ACC_W - 1){1'b0}}};
    localparam int                 c_pad      = 1 << CH_W;

    logic [NCH-1:0]   w_pending;
    logic [c_pad-1:0] w_pend_pad;
    logic             w_ch_ok;
    logic             w_accept;
    logic             r_cfg_err;

    // Out-of-range channel indices read as "not pending" so the write is
    // accepted and dropped rather than stalling the port.
    always_comb begin
        w_pend_pad = '0;
        for (int k = 0; k < NCH; k++) begin
            w_pend_pad[k] = w_pending[k];
        end
    end

    assign w_ch_ok   = ({1'b0, cfg_ch} < c_nch);
    assign cfg_ready = w_ch_ok ? ~w_pend_pad[cfg_ch] : 1'b1;
    assign w_accept  = cfg_valid & cfg_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_accept & ~w_ch_ok;
        end
    end

    assign cfg_err = r_cfg_err;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            localparam logic [CH_W-1:0] c_idx = CH_W'(gi);

            logic [ACC_W-1:0] r_acc;
            logic             r_en;
            logic [ACC_W-1:0] r_step;
            logic [ACC_W-1:0] r_duty;
            logic [ACC_W-1:0] r_phase;
            logic             r_sh_en;
            logic [ACC_W-1:0] r_sh_step;
            logic [ACC_W-1:0] r_sh_duty;
            logic [ACC_W-1:0] r_sh_phase;
            logic             r_pend;
            logic [OUT_W-1:0] r_wave;
            logic             r_wrap;

            logic [ACC_W:0]   w_sum;
            logic             w_carry;
            logic             w_apply;
            logic             w_write;
            logic             w_en_nxt;
            logic [ACC_W-1:0] w_phase_nxt;
            logic [ACC_W-1:0] w_acc_nxt;

            assign w_sum       = {1'b0, r_acc} + {1'b0, r_step};
            // sync realigns instead of accumulating, so it never produces a wrap
            assign w_carry     = r_en & w_sum[ACC_W] & ~sync;
            assign w_apply     = r_pend & (w_carry | sync | ~r_en);
            assign w_write     = w_accept & w_ch_ok & (cfg_ch == c_idx);
            assign w_en_nxt    = w_apply ? r_sh_en    : r_en;
            assign w_phase_nxt = w_apply ? r_sh_phase : r_phase;

            // Load phase when disabled, on sync, or on the 0->1 enable edge;
            // otherwise advance with the step that was active this cycle.
            always_comb begin
                w_acc_nxt = w_sum[ACC_W-1:0];
                if (!w_en_nxt || sync || !r_en) begin
                    w_acc_nxt = w_phase_nxt;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_acc      <= '0;
                    r_en       <= 1'b0;
                    r_step     <= '0;
                    r_duty     <= c_duty_rst;
                    r_phase    <= '0;
                    r_sh_en    <= 1'b0;
                    r_sh_step  <= '0;
                    r_sh_duty  <= '0;
                    r_sh_phase <= '0;
                    r_pend     <= 1'b0;
                    r_wave     <= '0;
                    r_wrap     <= 1'b0;
                end else begin
                    r_acc  <= w_acc_nxt;
                    r_wrap <= w_carry;
                    if (!r_en) begin
                        r_wave <= '0;
                    end else if (r_acc < r_duty) begin
                        r_wave <= c_high;
                    end else begin
                        r_wave <= c_low;
                    end
                    if (w_apply) begin
                        r_en    <= r_sh_en;
                        r_step  <= r_sh_step;
                        r_duty  <= r_sh_duty;
                        r_phase <= r_sh_phase;
                        r_pend  <= 1'b0;
                    end else if (w_write) begin
                        r_sh_en    <= cfg_en;
                        r_sh_step  <= cfg_step;
                        r_sh_duty  <= cfg_duty;
                        r_sh_phase <= cfg_phase;
                        r_pend     <= 1'b1;
                    end
                end
            end

            assign w_pending[gi]                 = r_pend;
            assign wave_out[gi*OUT_W +: OUT_W]   = r_wave;
            assign wrap[gi]                      = r_wrap;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_square_wave_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_square_wave_mc
//  Description : Bench for square_wave_mc against a cycle-level arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_square_wave_mc;

    localparam int    NCH   = 3;
    localparam int    ACC_W = 16;
    localparam int    OUT_W = 16;
    localparam int    CH_W  = 2;
    localparam longint MOD  = 65536;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 sync;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CH_W-1:0]      cfg_ch;
    logic                 cfg_en;
    logic [ACC_W-1:0]     cfg_step;
    logic [ACC_W-1:0]     cfg_duty;
    logic [ACC_W-1:0]     cfg_phase;
    logic                 cfg_err;
    logic [NCH*OUT_W-1:0] wave_out;
    logic [NCH-1:0]       wrap;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: per-channel state held as plain integers
    longint m_acc[NCH], m_step[NCH], m_duty[NCH], m_phase[NCH];
    longint s_step[NCH], s_duty[NCH], s_phase[NCH];
    bit     m_en[NCH], s_en[NCH], m_pend[NCH];
    longint e_wave[NCH];
    bit     e_wrap[NCH];
    bit     e_err;

    square_wave_mc #(
        .NCH   (NCH),
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .CH_W  (CH_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_en    (cfg_en),
        .cfg_step  (cfg_step),
        .cfg_duty  (cfg_duty),
        .cfg_phase (cfg_phase),
        .cfg_err   (cfg_err),
        .wave_out  (wave_out),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready(input int ch);
        return (ch >= NCH) ? 1'b1 : !m_pend[ch];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_acc[k] = 0; m_en[k] = 0; m_step[k] = 0; m_duty[k] = MOD / 2; m_phase[k] = 0;
            s_en[k] = 0; s_step[k] = 0; s_duty[k] = 0; s_phase[k] = 0; m_pend[k] = 0;
            e_wave[k] = 0; e_wrap[k] = 0;
        end
        e_err = 0;
    endtask

    // One clock of the behaviour, using the inputs currently driven
    task automatic model_step();
        int  ch;
        bit  take;
        ch   = int'(cfg_ch);
        take = cfg_valid && m_ready(ch);
        e_err = take && (ch >= NCH);
        for (int k = 0; k < NCH; k++) begin
            longint nxt;
            bit     was_en, wrapped;
            nxt     = m_acc[k] + m_step[k];
            was_en  = m_en[k];
            wrapped = was_en && !sync && (nxt >= MOD);
            e_wave[k] = !was_en ? 0 : ((m_acc[k] < m_duty[k]) ? 'h7FFF : 'h8000);
            e_wrap[k] = wrapped;
            if (m_pend[k] && (wrapped || sync || !was_en)) begin
                m_en[k] = s_en[k]; m_step[k] = s_step[k];
                m_duty[k] = s_duty[k]; m_phase[k] = s_phase[k];
                m_pend[k] = 0;
            end
            if (!m_en[k] || sync || !was_en) m_acc[k] = m_phase[k];
            else                             m_acc[k] = nxt % MOD;
        end
        if (take && ch < NCH) begin
            s_en[ch] = cfg_en; s_step[ch] = cfg_step;
            s_duty[ch] = cfg_duty; s_phase[ch] = cfg_phase;
            m_pend[ch] = 1;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("wave%0d", k), longint'(wave_out[k*OUT_W +: OUT_W]), e_wave[k]);
            chk($sformatf("wrap%0d", k), longint'(wrap[k]), longint'(e_wrap[k]));
        end
        chk("cfg_err", longint'(cfg_err), longint'(e_err));
    endtask

    // Called at a falling edge: drive, check ready, clock, then check outputs
    task automatic tick(input bit v, input int ch, input bit en, input int st,
                        input int du, input int ph, input bit sy);
        cfg_valid = v;
        cfg_ch    = CH_W'(ch);
        cfg_en    = en;
        cfg_step  = ACC_W'(st);
        cfg_duty  = ACC_W'(du);
        cfg_phase = ACC_W'(ph);
        sync      = sy;
        #1;
        chk("cfg_ready", longint'(cfg_ready), longint'(m_ready(ch)));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int ch, input bit en, input int st, input int du, input int ph);
        int t;
        t = 0;
        while (!m_ready(ch) && t < 200) begin
            idle(1);
            t++;
        end
        if (t >= 200) chk("wr_timeout", 1, 0);
        tick(1, ch, en, st, du, ph, 0);
    endtask

    task automatic check_reset_state();
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("rst_wave%0d", k), longint'(wave_out[k*OUT_W +: OUT_W]), 0);
            chk($sformatf("rst_wrap%0d", k), longint'(wrap[k]), 0);
        end
        chk("rst_cfg_err", longint'(cfg_err), 0);
        chk("rst_cfg_ready", longint'(cfg_ready), 1);
    endtask

    initial begin
        reset = 1'b1; sync = 0; cfg_valid = 0; cfg_ch = '0; cfg_en = 0;
        cfg_step = '0; cfg_duty = '0; cfg_phase = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;
        idle(4);

        // Basic 50 % wave, then a mid-period duty change taking effect at wrap
        wr(0, 1, 'h1000, 'h8000, 0);
        idle(40);
        wr(0, 1, 'h1000, 'h4000, 0);
        idle(40);

        // Two channels half a period apart after sync
        wr(0, 1, 'h1000, 'h8000, 0);
        wr(1, 1, 'h1000, 'h8000, 'h8000);
        idle(20);
        tick(0, 0, 0, 0, 0, 0, 1);
        idle(40);

        // Invalid channel write
        tick(1, 3, 1, 'h1234, 'h4321, 'h5555, 0);
        idle(4);

        // Static levels and maximum step on channel 2
        wr(2, 1, 0, 'hFFFF, 0);
        idle(10);
        wr(2, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 1);
        idle(10);
        wr(2, 1, 'hFFFF, 'h8000, 0);
        tick(0, 0, 0, 0, 0, 0, 1);
        idle(10);
        wr(2, 0, 'hFFFF, 'h8000, 0);
        wr(2, 1, 'hFFFF, 'h8000, 0);
        idle(10);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int st;
            case ($urandom_range(0, 4))
                0:       st = 0;
                1:       st = 'hFFFF;
                2:       st = int'($urandom_range(1, 'h0400));
                default: st = int'($urandom_range(0, 'hFFFF));
            endcase
            tick(($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) != 0), st,
                 int'($urandom_range(0, 'hFFFF)), int'($urandom_range(0, 'hFFFF)),
                 ($urandom_range(0, 39) == 0));
        end

        // Asynchronous reset in the middle of activity
        wr(0, 1, 'h0800, 'h8000, 0);
        idle(7);
        tick(1, 1, 1, 'h2000, 'h1000, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        idle(10);
        wr(1, 1, 'h1000, 'h8000, 0);
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/square_wave_mc.md
# square_wave_mc

Multi-channel, parametrised square-wave generator: NCH independent phase-accumulator channels, each with programmable step (frequency), full-resolution duty threshold and phase offset. Configuration goes through a valid/ready write port into per-channel shadow registers, which are applied glitch-free at the channel's phase wrap. A common sync input realigns all channels. Sits in the waveform-source tier, feeding the output mixer with signed full-scale samples.

## Interface
- NCH, 4, number of channels (1–16)
- ACC_W, 16, phase accumulator / step / duty / phase width (8–32)
- OUT_W, 16, output sample width per channel (2–32)
- CH_W, $clog2(NCH) min 1, channel index width (derived)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- sync  in  1  realign all enabled channels to their phase offsets
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write can be accepted (combinational)
- cfg_ch  in  CH_W  target channel
- cfg_en  in  1  channel enable
- cfg_step  in  ACC_W  phase increment per clock
- cfg_duty  in  ACC_W  high threshold: output high while acc < duty
- cfg_phase  in  ACC_W  accumulator load value on sync/enable
- cfg_err  out  1  one-cycle pulse: accepted write had cfg_ch >= NCH
- wave_out  out  NCH*OUT_W  channel samples, channel k at [k*OUT_W +: OUT_W], signed
- wrap  out  NCH  one-cycle pulse per channel on accumulator carry-out

## Operation
- Per channel: acc, active {en, step, duty, phase}, shadow {en, step, duty, phase}, pending flag.
- Write accepted when cfg_valid & cfg_ready. cfg_ready = !pending[cfg_ch] for cfg_ch < NCH; 1 for cfg_ch >= NCH (write dropped, cfg_err pulses next cycle).
- Accepted write: shadow <= cfg fields, pending <= 1.
- Apply (active <= shadow, pending <= 0) on the first cycle where pending and any of: channel carry-out, sync, or active en = 0.
- Enabled channel, no sync: acc <= (acc + step) mod 2^ACC_W; carry-out = wrap event. Step, duty and phase applied at wrap take effect from the next cycle; acc on the wrap cycle uses the old step.
- sync (enabled channels, or channels being enabled by the apply that cycle): acc <= phase, using the newly applied phase if an apply occurs that cycle. No wrap pulse from sync.
- Disabled channel: acc <= active phase (held), wave_out = 0, no wrap.
- Sample: high = 2^(OUT_W-1)-1 (e.g. 0x7FFF), low = -2^(OUT_W-1) (0x8000). duty = 0 → always low; step = 0 → static level.
- Enable transition 0→1 (via apply): acc loaded with phase that cycle, accumulation starts next cycle.

## Timing
- Reset values: acc 0, active en 0, step 0, duty 2^(ACC_W-1), phase 0, all shadows 0, pending 0, wave_out 0, wrap 0, cfg_err 0, cfg_ready 1.
- wave_out registered: wave_out(t+1) = f(acc(t), duty(t), en(t)); 1-cycle latency from acc.
- wrap registered: high the cycle after the carry-out edge, exactly one cycle.
- cfg_err: one cycle, cycle after acceptance.
- cfg_ready falls the cycle after acceptance on that channel; rises the cycle after apply. Max one outstanding write per channel; back-to-back writes to different channels accepted every cycle.
- Write and apply in same cycle on same channel cannot occur (ready low while pending).
- Reset mid-operation: all state to reset values immediately; pending writes discarded.

## Test plan
- Reset: assert reset mid-run → wave_out = 0, wrap = 0, cfg_ready = 1, cfg_err = 0 asynchronously; held after release until config.
- ACC_W=16, OUT_W=16, ch0 en=1, step=0x1000, duty=0x8000, phase=0 → period 16 cycles, 8× 0x7FFF then 8× 0x8000, wrap every 16 cycles.
- Mid-period write ch0 duty=0x4000 → cfg_ready low until next wrap; new 4-high/12-low pattern starts exactly after wrap; no runt pulse.
- ch0 phase=0, ch1 phase=0x8000, same step 0x1000, pulse sync → ch1 is ch0 inverted; wrap pulses 8 cycles apart.
- Write cfg_ch=NCH (invalid) → accepted, cfg_err one-cycle pulse, no channel state changes.
- step=0, duty=0xFFFF, en=1 → constant 0x7FFF, no wrap; duty=0 → constant 0x8000; step=0xFFFF → wrap every cycle except the first after enable.
